// File: rtl/processor_stage2_pkg.sv
// Shared definitions for the decode stage: opcodes, code-word field positions
// and register index width.
package processor_stage2_pkg;

  localparam int REG_IDX_SIZE = 3;

  // Code-word field bit positions (18-bit instruction word)
  localparam int OPC_MSB  = 17;
  localparam int OPC_LSB  = 14;
  localparam int DST_MSB  = 13;
  localparam int DST_LSB  = 11;
  localparam int SRC0_MSB = 10;
  localparam int SRC0_LSB = 8;
  localparam int SRC1_MSB = 7;
  localparam int SRC1_LSB = 5;
  localparam int IMM8_MSB = 7;
  localparam int IMM14_MSB = 13;

  typedef logic [REG_IDX_SIZE-1:0] reg_idx_t;

  // Opcodes 7..15 are reserved and decode exactly like OP_NOP
  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_ALU    = 4'd1,
    OP_ADDI   = 4'd2,
    OP_LOAD   = 4'd3,
    OP_STORE  = 4'd4,
    OP_CALL   = 4'd5,
    OP_RETURN = 4'd6
  } opcode_t;

  // Read-port enable bit assignments for the hazard compare
  localparam int RD_SRC0 = 0;
  localparam int RD_SRC1 = 1;
  localparam int RD_DST  = 2;

endpackage

// File: rtl/processor_scoreboard.sv
// Two-entry RAW scoreboard: a shift register of recently issued register writes
// plus the combinational compare against the registers the incoming word reads.
// Build option PROCESSOR_FORWARDING_EN: only entry0 is tracked and only a LOAD
// in entry0 causes a hazard (ALU results are forwarded by execute).
module processor_scoreboard
  import processor_stage2_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     advance,
  input  logic     push_valid,
`ifdef PROCESSOR_FORWARDING_EN
  input  logic     push_is_load,
`endif
  input  reg_idx_t push_reg,
  input  logic [2:0] rd_en,
  input  reg_idx_t rd_reg0,
  input  reg_idx_t rd_reg1,
  input  reg_idx_t rd_reg2,
  output logic     hazard
);

  logic     e0_valid;
  reg_idx_t e0_reg;

  // True when any enabled read port names register r
  function automatic logic reads_reg(input logic [2:0] en, input reg_idx_t r0,
                                     input reg_idx_t r1, input reg_idx_t r2,
                                     input reg_idx_t r);
    return (en[0] && r0 == r) || (en[1] && r1 == r) || (en[2] && r2 == r);
  endfunction

`ifdef PROCESSOR_FORWARDING_EN
  logic e0_load;

  // Entry0 shift: a new push (or an empty slot) replaces the previous entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e0_valid <= 1'b0;
      e0_load  <= 1'b0;
      e0_reg   <= '0;
    end else if (advance) begin
      e0_valid <= push_valid;
      e0_load  <= push_valid & push_is_load;
      e0_reg   <= push_valid ? push_reg : '0;
    end
  end

  // Load-use only: result of a LOAD is not forwardable in the next cycle
  always_comb begin
    hazard = e0_valid && e0_load && reads_reg(rd_en, rd_reg0, rd_reg1, rd_reg2, e0_reg);
  end
`else
  logic     e1_valid;
  reg_idx_t e1_reg;

  // Two-deep shift: entry0 moves to entry1, new push (or empty) enters entry0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      e0_valid <= 1'b0;
      e0_reg   <= '0;
      e1_valid <= 1'b0;
      e1_reg   <= '0;
    end else if (advance) begin
      e1_valid <= e0_valid;
      e1_reg   <= e0_reg;
      e0_valid <= push_valid;
      e0_reg   <= push_valid ? push_reg : '0;
    end
  end

  // Any pending writer in either entry blocks a reader of that register
  always_comb begin
    hazard = (e0_valid && reads_reg(rd_en, rd_reg0, rd_reg1, rd_reg2, e0_reg)) ||
             (e1_valid && reads_reg(rd_en, rd_reg0, rd_reg1, rd_reg2, e1_reg));
  end
`endif

endmodule

// File: rtl/processor_stage2.sv
// Instruction decode stage. Latches the code word for the fetched ip, splits it
// into fields, and holds fetch (hazard_stall) while a RAW hazard is pending.
// Build option PROCESSOR_FORWARDING_EN selects the load-use-only scoreboard.
//
// Slot handshake: an input slot carries an instruction when no_operation_in=0.
// It is consumed on a clock edge only when flush=0, stall_in=0 and no hazard;
// otherwise hazard_stall tells fetch to present the same word again. flush kills
// the slot (consumed as a bubble); stall_in freezes every register in the stage.
module processor_stage2
  import processor_stage2_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 no_operation_in,
  input  logic [ADDR_SIZE-1:0] ip_in,
  input  logic [ADDR_SIZE-1:0] ip_plus_one_in,
  input  logic [WORD_SIZE-1:0] code_word,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic                 no_operation_out,
  output logic [ADDR_SIZE-1:0] ip_out,
  output logic [ADDR_SIZE-1:0] ip_plus_one_out,
  output logic [3:0]           opcode_out,
  output logic [2:0]           reg_dst_out,
  output logic [2:0]           reg_src0_out,
  output logic [2:0]           reg_src1_out,
  output logic [WORD_SIZE-1:0] imm_out,
  output logic                 writes_reg_out,
  output logic                 is_call_out,
  output logic                 is_return_out,
  output logic                 is_load_out
);

  logic [3:0]           dec_opcode;
  reg_idx_t             dec_dst, dec_src0, dec_src1;
  logic [WORD_SIZE-1:0] dec_imm;
  logic                 dec_writes, dec_call, dec_ret, dec_load;
  logic [2:0]           dec_rd_en;
  logic [2:0]           sb_rd_en;
  logic                 hazard, issue, sb_advance;

  assign dec_opcode = code_word[OPC_MSB:OPC_LSB];
  assign dec_dst    = code_word[DST_MSB:DST_LSB];
  assign dec_src0   = code_word[SRC0_MSB:SRC0_LSB];
  assign dec_src1   = code_word[SRC1_MSB:SRC1_LSB];

  // Opcode decode: flags, immediate form and which register fields are read
  always_comb begin
    dec_writes = 1'b0;
    dec_call   = 1'b0;
    dec_ret    = 1'b0;
    dec_load   = 1'b0;
    dec_rd_en  = 3'b000;
    dec_imm    = '0;
    case (dec_opcode)
      OP_ALU: begin
        dec_writes         = 1'b1;
        dec_rd_en[RD_SRC0] = 1'b1;
        dec_rd_en[RD_SRC1] = 1'b1;
      end
      OP_ADDI: begin
        dec_writes         = 1'b1;
        dec_rd_en[RD_SRC0] = 1'b1;
        dec_imm = {{(WORD_SIZE-8){code_word[IMM8_MSB]}}, code_word[IMM8_MSB:0]};
      end
      OP_LOAD: begin
        dec_writes         = 1'b1;
        dec_load           = 1'b1;
        dec_rd_en[RD_SRC0] = 1'b1;
        dec_imm = {{(WORD_SIZE-8){code_word[IMM8_MSB]}}, code_word[IMM8_MSB:0]};
      end
      OP_STORE: begin
        dec_rd_en[RD_SRC0] = 1'b1;
        dec_rd_en[RD_DST]  = 1'b1;
        dec_imm = {{(WORD_SIZE-8){code_word[IMM8_MSB]}}, code_word[IMM8_MSB:0]};
      end
      OP_CALL: begin
        dec_call = 1'b1;
        dec_imm  = {{(WORD_SIZE-14){1'b0}}, code_word[IMM14_MSB:0]};
      end
      OP_RETURN: dec_ret = 1'b1;
      default: ;
    endcase
  end

  // Slot control: a bubble reads nothing; flush overrides stall and hazard
  always_comb begin
    sb_rd_en     = no_operation_in ? 3'b000 : dec_rd_en;
    hazard_stall = !flush && (stall_in || hazard);
    issue        = !flush && !stall_in && !no_operation_in && !hazard;
    sb_advance   = flush || !stall_in;
  end

  processor_scoreboard u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .advance      (sb_advance),
    .push_valid   (issue && dec_writes),
`ifdef PROCESSOR_FORWARDING_EN
    .push_is_load (dec_load),
`endif
    .push_reg     (dec_dst),
    .rd_en        (sb_rd_en),
    .rd_reg0      (dec_src0),
    .rd_reg1      (dec_src1),
    .rd_reg2      (dec_dst),
    .hazard       (hazard)
  );

  // Decoded-instruction register: load on issue, bubble on any other advance
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      no_operation_out <= 1'b1;
      ip_out           <= '0;
      ip_plus_one_out  <= '0;
      opcode_out       <= '0;
      reg_dst_out      <= '0;
      reg_src0_out     <= '0;
      reg_src1_out     <= '0;
      imm_out          <= '0;
      writes_reg_out   <= 1'b0;
      is_call_out      <= 1'b0;
      is_return_out    <= 1'b0;
      is_load_out      <= 1'b0;
    end else if (sb_advance) begin
      no_operation_out <= !issue;
      ip_out           <= issue ? ip_in : '0;
      ip_plus_one_out  <= issue ? ip_plus_one_in : '0;
      opcode_out       <= issue ? dec_opcode : '0;
      reg_dst_out      <= issue ? dec_dst : '0;
      reg_src0_out     <= issue ? dec_src0 : '0;
      reg_src1_out     <= issue ? dec_src1 : '0;
      imm_out          <= issue ? dec_imm : '0;
      writes_reg_out   <= issue && dec_writes;
      is_call_out      <= issue && dec_call;
      is_return_out    <= issue && dec_ret;
      is_load_out      <= issue && dec_load;
    end
  end

endmodule

// File: tb/tb_processor_stage2.sv
// Directed testbench for processor_stage2 (default and PROCESSOR_FORWARDING_EN builds).
module tb_processor_stage2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        no_operation_in, stall_in, flush;
  logic [17:0] ip_in, ip_plus_one_in, code_word;
  logic        hazard_stall, no_operation_out;
  logic [17:0] ip_out, ip_plus_one_out, imm_out;
  logic [3:0]  opcode_out;
  logic [2:0]  reg_dst_out, reg_src0_out, reg_src1_out;
  logic        writes_reg_out, is_call_out, is_return_out, is_load_out;

  int vecs = 0;
  int errs = 0;

  // Observed bundle: {nop, opcode, dst, src0, src1, imm, writes, call, ret, load}
  logic [35:0] obs;
  logic [35:0] exp_q[$];

  assign obs = {no_operation_out, opcode_out, reg_dst_out, reg_src0_out, reg_src1_out,
                imm_out, writes_reg_out, is_call_out, is_return_out, is_load_out};

  localparam logic [35:0] BUBBLE = {1'b1, 35'd0};

`ifdef PROCESSOR_FORWARDING_EN
  localparam int NB_ALU = 0, NB_LOAD = 1, NB_FLUSH = 0, HZ_STREAM = 0;
`else
  localparam int NB_ALU = 2, NB_LOAD = 2, NB_FLUSH = 1, HZ_STREAM = 2;
`endif

  processor_stage2 dut (
    .clock(clock), .reset(reset), .no_operation_in(no_operation_in),
    .ip_in(ip_in), .ip_plus_one_in(ip_plus_one_in), .code_word(code_word),
    .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
    .no_operation_out(no_operation_out), .ip_out(ip_out), .ip_plus_one_out(ip_plus_one_out),
    .opcode_out(opcode_out), .reg_dst_out(reg_dst_out), .reg_src0_out(reg_src0_out),
    .reg_src1_out(reg_src1_out), .imm_out(imm_out), .writes_reg_out(writes_reg_out),
    .is_call_out(is_call_out), .is_return_out(is_return_out), .is_load_out(is_load_out)
  );

  // Clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Code word builder: {opcode, dst, src0, low byte}
  function automatic logic [17:0] mk(input logic [3:0] op, input logic [2:0] d,
                                     input logic [2:0] s0, input logic [7:0] lo);
    return {op, d, s0, lo};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic nop, input logic [17:0] ip, input logic [17:0] cw,
                       input logic st, input logic fl);
    no_operation_in = nop;
    ip_in           = ip;
    ip_plus_one_in  = ip + 18'd1;
    code_word       = cw;
    stall_in        = st;
    flush           = fl;
  endtask

  task automatic idle2;
    drive(1'b1, 18'd0, 18'd0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  // Reset at power-up: bubble, zero outputs, no stall
  task automatic test_reset;
    reset = 1'b0;
    drive(1'b1, 18'd0, 18'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL reset_bundle: got %h want %h", obs, BUBBLE); end
    vecs++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL reset_hs: got %b want 0", hazard_stall); end
    vecs++; if ({ip_out, ip_plus_one_out} !== 36'd0) begin errs++; $display("FAIL reset_ip: got %h want 0", {ip_out, ip_plus_one_out}); end
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  // ADDI r1,r2,-3: sign-extended immediate, writer flag
  task automatic test_addi;
    logic [35:0] e;
    e = {1'b0, 4'd2, 3'd1, 3'd2, 3'd7, 18'h3FFFD, 4'b1000};
    drive(1'b0, 18'd10, mk(4'd2, 3'd1, 3'd2, 8'hFD), 1'b0, 1'b0);
    #1;
    vecs++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL addi_hs: got %b want 0", hazard_stall); end
    tick();
    vecs++; if (obs !== e) begin errs++; $display("FAIL addi_bundle: got %h want %h", obs, e); end
    vecs++; if ({ip_out, ip_plus_one_out} !== {18'd10, 18'd11}) begin errs++; $display("FAIL addi_ip: got %h want %h", {ip_out, ip_plus_one_out}, {18'd10, 18'd11}); end
    drive(1'b1, 18'd0, 18'd0, 1'b0, 1'b0);
    tick();
    vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL addi_bubble_in: got %h want %h", obs, BUBBLE); end
    tick();
  endtask

  // Reset asserted mid-cycle while a hazard is pending: immediate effect
  task automatic test_async_reset;
    logic [35:0] e_ld, e_alu;
    e_ld  = {1'b0, 4'd3, 3'd1, 3'd2, 3'd0, 18'h00000, 4'b1001};
    e_alu = {1'b0, 4'd1, 3'd6, 3'd1, 3'd0, 18'h00000, 4'b1000};
    drive(1'b0, 18'd30, mk(4'd3, 3'd1, 3'd2, 8'h00), 1'b0, 1'b0);
    tick();
    vecs++; if (obs !== e_ld) begin errs++; $display("FAIL arst_load: got %h want %h", obs, e_ld); end
    drive(1'b0, 18'd31, mk(4'd1, 3'd6, 3'd1, 8'h00), 1'b0, 1'b0);
    #1;
    vecs++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL arst_pre_hs: got %b want 1", hazard_stall); end
    #2;
    reset = 1'b0;
    #1;
    vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL arst_bundle: got %h want %h", obs, BUBBLE); end
    vecs++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL arst_hs: got %b want 0", hazard_stall); end
    vecs++; if (ip_out !== 18'd0) begin errs++; $display("FAIL arst_ip: got %h want 0", ip_out); end
    @(negedge clock);
    reset = 1'b1;
    tick();
    vecs++; if (obs !== e_alu) begin errs++; $display("FAIL arst_sb_empty: got %h want %h", obs, e_alu); end
    vecs++; if (ip_out !== 18'd31) begin errs++; $display("FAIL arst_ip_after: got %h want 1f", ip_out); end
    idle2();
  endtask

  // ALU r3 then ALU reading r3
  task automatic test_alu_raw;
    logic [35:0] e_a, e_b;
    e_a = {1'b0, 4'd1, 3'd3, 3'd1, 3'd2, 18'h00000, 4'b1000};
    e_b = {1'b0, 4'd1, 3'd6, 3'd3, 3'd0, 18'h00000, 4'b1000};
    drive(1'b0, 18'd40, mk(4'd1, 3'd3, 3'd1, 8'h40), 1'b0, 1'b0);
    tick();
    vecs++; if (obs !== e_a) begin errs++; $display("FAIL alu_first: got %h want %h", obs, e_a); end
    drive(1'b0, 18'd41, mk(4'd1, 3'd6, 3'd3, 8'h00), 1'b0, 1'b0);
    for (int k = 0; k <= NB_ALU; k++) begin
      #1;
      vecs++; if (hazard_stall !== (k < NB_ALU)) begin errs++; $display("FAIL alu_hs_%0d: got %b want %b", k, hazard_stall, k < NB_ALU); end
      tick();
      if (k < NB_ALU) begin
        vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL alu_bubble_%0d: got %h want %h", k, obs, BUBBLE); end
      end else begin
        vecs++; if (obs !== e_b) begin errs++; $display("FAIL alu_issue: got %h want %h", obs, e_b); end
      end
    end
    idle2();
  endtask

  // LOAD r4 then ADDI r5,r4,+1
  task automatic test_load_use;
    logic [35:0] e_ld, e_ad;
    e_ld = {1'b0, 4'd3, 3'd4, 3'd1, 3'd0, 18'h00005, 4'b1001};
    e_ad = {1'b0, 4'd2, 3'd5, 3'd4, 3'd0, 18'h00001, 4'b1000};
    drive(1'b0, 18'd60, mk(4'd3, 3'd4, 3'd1, 8'h05), 1'b0, 1'b0);
    tick();
    vecs++; if (obs !== e_ld) begin errs++; $display("FAIL ld_first: got %h want %h", obs, e_ld); end
    drive(1'b0, 18'd61, mk(4'd2, 3'd5, 3'd4, 8'h01), 1'b0, 1'b0);
    for (int k = 0; k <= NB_LOAD; k++) begin
      #1;
      vecs++; if (hazard_stall !== (k < NB_LOAD)) begin errs++; $display("FAIL ld_hs_%0d: got %b want %b", k, hazard_stall, k < NB_LOAD); end
      tick();
      if (k < NB_LOAD) begin
        vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL ld_bubble_%0d: got %h want %h", k, obs, BUBBLE); end
      end else begin
        vecs++; if (obs !== e_ad) begin errs++; $display("FAIL ld_issue: got %h want %h", obs, e_ad); end
      end
    end
    idle2();
  endtask

  // stall_in for 3 cycles while a load-use hazard waits: everything holds
  task automatic test_stall;
    logic [35:0] e_ld, e_ad;
    e_ld = {1'b0, 4'd3, 3'd4, 3'd1, 3'd0, 18'h00005, 4'b1001};
    e_ad = {1'b0, 4'd2, 3'd5, 3'd4, 3'd0, 18'h00001, 4'b1000};
    drive(1'b0, 18'd70, mk(4'd3, 3'd4, 3'd1, 8'h05), 1'b0, 1'b0);
    tick();
    drive(1'b0, 18'd71, mk(4'd2, 3'd5, 3'd4, 8'h01), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      vecs++; if (hazard_stall !== 1'b1) begin errs++; $display("FAIL stall_hs_%0d: got %b want 1", k, hazard_stall); end
      tick();
      vecs++; if ({obs, ip_out} !== {e_ld, 18'd70}) begin errs++; $display("FAIL stall_hold_%0d: got %h want %h", k, {obs, ip_out}, {e_ld, 18'd70}); end
    end
    stall_in = 1'b0;
    for (int k = 0; k <= NB_LOAD; k++) begin
      #1;
      vecs++; if (hazard_stall !== (k < NB_LOAD)) begin errs++; $display("FAIL stall_rel_hs_%0d: got %b want %b", k, hazard_stall, k < NB_LOAD); end
      tick();
      if (k < NB_LOAD) begin
        vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL stall_bubble_%0d: got %h want %h", k, obs, BUBBLE); end
      end else begin
        vecs++; if (obs !== e_ad) begin errs++; $display("FAIL stall_issue: got %h want %h", obs, e_ad); end
      end
    end
    idle2();
  endtask

  // flush coincident with a hazard: bubble, no stall, scoreboard advances
  task automatic test_flush;
    logic [35:0] e_ad;
    e_ad = {1'b0, 4'd2, 3'd5, 3'd4, 3'd0, 18'h00001, 4'b1000};
    drive(1'b0, 18'd80, mk(4'd3, 3'd4, 3'd1, 8'h05), 1'b0, 1'b0);
    tick();
    drive(1'b0, 18'd81, mk(4'd2, 3'd5, 3'd4, 8'h01), 1'b0, 1'b1);
    #1;
    vecs++; if (hazard_stall !== 1'b0) begin errs++; $display("FAIL flush_hs: got %b want 0", hazard_stall); end
    tick();
    vecs++; if (obs !== BUBBLE) begin errs++; $display("FAIL flush_bubble: got %h want %h", obs, BUBBLE); end
    flush = 1'b0;
    for (int k = 0; k <= NB_FLUSH; k++) begin
      #1;
      vecs++; if (hazard_stall !== (k < NB_FLUSH)) begin errs++; $display("FAIL flush_after_hs_%0d: got %b want %b", k, hazard_stall, k < NB_FLUSH); end
      tick();
      if (k == NB_FLUSH) begin
        vecs++; if (obs !== e_ad) begin errs++; $display("FAIL flush_issue: got %h want %h", obs, e_ad); end
      end
    end
    idle2();
  endtask

  // Mixed stream through a re-presenting fetch model; exp_q holds issued bundles
  task automatic test_back_to_back;
    logic [17:0] words [7];
    logic [35:0] exps  [7];
    logic [35:0] e;
    int idx, hz;
    logic adv;
    words[0] = mk(4'd2, 3'd7, 3'd7, 8'h7F);  exps[0] = {1'b0, 4'd2, 3'd7, 3'd7, 3'd3, 18'h0007F, 4'b1000};
    words[1] = mk(4'd1, 3'd3, 3'd1, 8'h40);  exps[1] = {1'b0, 4'd1, 3'd3, 3'd1, 3'd2, 18'h00000, 4'b1000};
    words[2] = 18'h16ABC;                    exps[2] = {1'b0, 4'd5, 3'd5, 3'd2, 3'd5, 18'h02ABC, 4'b0100};
    words[3] = 18'h18000;                    exps[3] = {1'b0, 4'd6, 3'd0, 3'd0, 3'd0, 18'h00000, 4'b0010};
    words[4] = 18'h241FF;                    exps[4] = {1'b0, 4'd9, 3'd0, 3'd1, 3'd7, 18'h00000, 4'b0000};
    words[5] = mk(4'd2, 3'd2, 3'd0, 8'h80);  exps[5] = {1'b0, 4'd2, 3'd2, 3'd0, 3'd4, 18'h3FF80, 4'b1000};
    words[6] = mk(4'd4, 3'd2, 3'd3, 8'h10);  exps[6] = {1'b0, 4'd4, 3'd2, 3'd3, 3'd0, 18'h00010, 4'b0000};
    idx = 0;
    hz  = 0;
    for (int cyc = 0; cyc < 40 && (idx < 7 || exp_q.size() > 0); cyc++) begin
      if (idx < 7) drive(1'b0, 18'd100 + 18'(idx), words[idx], 1'b0, 1'b0);
      else drive(1'b1, 18'd0, 18'd0, 1'b0, 1'b0);
      #1;
      if (hazard_stall) hz++;
      adv = (idx < 7) && !hazard_stall;
      if (adv) exp_q.push_back(exps[idx]);
      tick();
      if (!no_operation_out) begin
        if (exp_q.size() == 0) begin
          vecs++; errs++; $display("FAIL b2b_unexpected: got %h want bubble", obs);
        end else begin
          e = exp_q.pop_front();
          vecs++; if (obs !== e) begin errs++; $display("FAIL b2b_issue: got %h want %h", obs, e); end
        end
      end
      if (adv) idx++;
    end
    vecs++; if (idx != 7 || exp_q.size() != 0) begin errs++; $display("FAIL b2b_drain: got %0d issued want 7", idx); end
    vecs++; if (hz != HZ_STREAM) begin errs++; $display("FAIL b2b_hazards: got %0d want %0d", hz, HZ_STREAM); end
    idle2();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_async_reset();
    test_alu_raw();
    test_load_use();
    test_stall();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
